uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8)
  DATA_W, 8, frame payload width
  GAP_CYC, 2, idle clocks enforced between frames
  TIMEOUT_CYC, 20000, max clocks waiting for done_tx; 0 disables timeout
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single system clock, all logic on rising edge
  rst_n  input  1  reset, asynchronous assert, active-low
  req  input  NUM_REQ  per-requester level request; payload valid while high
  req_data  input  NUM_REQ*DATA_W  payloads, requester i at bits [i*DATA_W +: DATA_W]
  gnt  output  NUM_REQ  one-hot one-cycle pulse: payload captured
  done  output  NUM_REQ  one-hot one-cycle pulse: frame for that requester completed
  din_tx  output  DATA_W  byte to transmitter
  data_update  output  1  transmit enable to transmitter
  done_tx  input  1  transmitter completion flag; rising edge is the event
  busy  output  1  high in any state other than IDLE
  timeout_err  output  1  one-cycle pulse on timeout abort

Function
REQ-003 FSM states SHALL be IDLE, SEND, GAP; one frame in flight at a time.
REQ-004 IDLE: if any req bit high at rising edge n, the block SHALL select one requester, register din_tx, pulse gnt for cycle n+1, raise data_update in cycle n+1, and enter SEND.
REQ-005 Selection SHALL be round-robin: search from (last_granted+1) mod NUM_REQ upward with wrap; last_granted resets to NUM_REQ-1, so requester 0 wins first.
REQ-006 A requester whose req drops before selection SHALL NOT be granted; req/req_data changes after gnt SHALL NOT affect din_tx.
REQ-007 din_tx SHALL hold the captured value until the next grant.
REQ-008 SEND: data_update SHALL stay high; done_tx is sampled each clock; a 0->1 transition SHALL, in the next cycle, pulse done[owner], drop data_update, and enter GAP.
REQ-009 SEND SHALL count clocks; if TIMEOUT_CYC>0 and the count reaches TIMEOUT_CYC with no done_tx edge, the block SHALL pulse timeout_err, drop data_update, not pulse done, and enter GAP.
REQ-010 A done_tx edge in the same cycle the count reaches TIMEOUT_CYC SHALL be treated as completion; timeout_err stays low.
REQ-011 done_tx already high on entry to SEND SHALL NOT count as completion; an edge is required.
REQ-012 GAP SHALL last exactly GAP_CYC clocks with data_update low, then return to IDLE; GAP_CYC=0 SHALL return to IDLE on the next clock.
REQ-013 Requests arriving during SEND/GAP SHALL be held pending by the requester and arbitrated on return to IDLE.
REQ-014 Timeout counter width SHALL be $clog2(TIMEOUT_CYC+1), minimum 1; GAP counter width $clog2(GAP_CYC+1), minimum 1.

Reset
REQ-015 rst_n low SHALL immediately force: state IDLE, gnt=0, done=0, din_tx=0, data_update=0, busy=0, timeout_err=0, counters 0, last_granted=NUM_REQ-1, done_tx edge register 0.
REQ-016 Reset mid-frame SHALL abandon the frame with no done or timeout_err pulse; the first grant after release follows REQ-004.

Structure
REQ-017 Shared package uart_ctrl_pkg SHALL hold the state enum (IDLE, SEND, GAP) and default parameter constants.
REQ-018 Round-robin selection SHALL be one combinational sub-module, uart_rr_arbiter (inputs req, last_granted; output one-hot grant, index); FSM, counters and datapath stay in uart_tx_arbiter.

Verification (bench instantiates with the existing UART top-level, clk_freq 1E6, baud 9600; TIMEOUT_CYC=2000 unless stated)
REQ-019 Single request: req=4'b0001, req_data[7:0]=8'hA5 -> gnt=0001 one cycle later, din_tx=A5, serial line carries A5 LSB first, done=0001 exactly once.
REQ-020 Contention: req=4'b1111 held, payloads 11/22/33/44 -> grants 0,1,2,3,0 in order; each data_update low phase lasts GAP_CYC clocks.
REQ-021 Wrap: last grant 3, req=4'b1001 -> requester 0 next, then 3.
REQ-022 Timeout: stub done_tx tied 0 -> timeout_err pulses 2000 clocks after entering SEND, no done pulse, next grant proceeds; TIMEOUT_CYC=0 -> never times out.
REQ-023 Reset mid-frame: rst_n low 5 clocks during SEND -> all outputs at reset values same cycle, no done; after release requester 0 granted first.
REQ-024 Coincident done_tx edge and timeout count -> done pulses, timeout_err stays 0.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART transmit arbiter.
//   uart_state_e  - transmit FSM states (IDLE, SEND, GAP)
//   DEF_*         - default parameter values for uart_tx_arbiter
//   cnt_width()   - bits needed for a counter reaching max_val (minimum 1)
package uart_ctrl_pkg;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_GAP_CYC     = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 20000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } uart_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin selector.
//   req          - per-requester request levels
//   last_granted - index of the most recent winner; search starts one above it
//   grant        - one-hot winner (all zero when no request)
//   grant_idx    - binary index of the winner
//   grant_vld    - at least one request present
module uart_rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_granted,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_vld
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand_idx  = '0;
    // i = NUM_REQ wraps back to last_granted itself, so it is checked last
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IDX_W'((32'(last_granted) + i) % NUM_REQ);
      if (!grant_vld && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ requesters.
//   clk, rst_n   - system clock, asynchronous active-low reset
//   req          - per-requester level request (payload valid while high)
//   req_data     - payloads, requester i at [i*DATA_W +: DATA_W]
//   gnt          - one-hot pulse: payload captured into din_tx
//   done         - one-hot pulse: frame of that requester completed
//   din_tx       - byte to transmitter, held until the next grant
//   data_update  - transmit enable, high throughout SEND
//   done_tx      - transmitter completion flag, rising edge is the event
//   busy         - high outside IDLE
//   timeout_err  - pulse when a frame is abandoned for lack of done_tx
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         din_tx,
  output logic                      data_update,
  input  logic                      done_tx,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYC);
  localparam int unsigned GAP_W = cnt_width(GAP_CYC);

  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  uart_state_e        state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  din_tx_q, din_tx_d;
  logic               timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               done_tx_q, done_tx_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic               tx_rise;

  uart_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req          (req),
    .last_granted (last_q),
    .grant        (arb_grant),
    .grant_idx    (arb_idx),
    .grant_vld    (arb_vld)
  );

  // done_tx is tracked in every state, so a level already high when SEND
  // is entered shows no edge and cannot complete the frame.
  assign tx_rise = done_tx & ~done_tx_q;

  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    done_d        = '0;
    timeout_err_d = 1'b0;
    din_tx_d      = din_tx_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    last_d        = last_q;
    owner_d       = owner_q;
    done_tx_d     = done_tx;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_grant;
          din_tx_d = req_data[arb_idx*DATA_W +: DATA_W];
          last_d   = arb_idx;
          owner_d  = arb_idx;
          to_cnt_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (TIMEOUT_CYC != 0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        // completion wins over a timeout reached on the same clock
        if (tx_rise) begin
          done_d[owner_q] = 1'b1;
          gap_cnt_d       = '0;
          state_d         = GAP;
        end else if ((TIMEOUT_CYC != 0) && (to_cnt_d == TO_LIM)) begin
          timeout_err_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      done_q        <= '0;
      din_tx_q      <= '0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      last_q        <= LAST_RST;
      owner_q       <= '0;
      done_tx_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      din_tx_q      <= din_tx_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      done_tx_q     <= done_tx_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign din_tx      = din_tx_q;
  assign timeout_err = timeout_err_q;
  assign data_update = (state_q == SEND);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
// The bench plays the transmitter, driving done_tx edges itself.
// dut  : NUM_REQ=4, DATA_W=8, GAP_CYC=2, TIMEOUT_CYC=2000
// dut0 : same but GAP_CYC=0, TIMEOUT_CYC=0 (timeout disabled)
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  din_tx;
  logic        data_update;
  logic        done_tx;
  logic        busy;
  logic        timeout_err;

  logic [3:0]  req0;
  logic [31:0] req_data0;
  logic [3:0]  gnt0;
  logic [3:0]  done0;
  logic [7:0]  din_tx0;
  logic        data_update0;
  logic        done_tx0;
  logic        busy0;
  logic        timeout_err0;

  int checks;
  int failures;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .GAP_CYC     (2),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .din_tx      (din_tx),
    .data_update (data_update),
    .done_tx     (done_tx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .GAP_CYC     (0),
    .TIMEOUT_CYC (0)
  ) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req0),
    .req_data    (req_data0),
    .gnt         (gnt0),
    .done        (done0),
    .din_tx      (din_tx0),
    .data_update (data_update0),
    .done_tx     (done_tx0),
    .busy        (busy0),
    .timeout_err (timeout_err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the next grant on dut and checks winner and payload.
  task automatic wait_grant(input logic [3:0] exp_gnt, input logic [7:0] exp_din, input string tag);
    int n;
    n = 0;
    while (gnt == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    check({tag, "_din"}, 64'(din_tx), 64'(exp_din));
  endtask

  // Produces a done_tx edge after lat clocks, checks the done pulse,
  // then measures the GAP phase (busy with data_update low).
  task automatic finish_frame(input logic [3:0] exp_done, input int lat, input string tag);
    int g;
    int extra;
    repeat (lat) tick();
    done_tx = 1'b1;
    tick();
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_du_low"}, 64'(data_update), 64'(0));
    check({tag, "_no_te"}, 64'(timeout_err), 64'(0));
    done_tx = 1'b0;
    g = 0;
    extra = 0;
    while (busy && !data_update && g < 20) begin
      g++;
      tick();
      if (done != 4'b0000) extra++;
    end
    check({tag, "_gap_len"}, 64'(g), 64'(2));
    check({tag, "_done_once"}, 64'(extra), 64'(0));
  endtask

  initial begin
    int n;
    int cnt;
    logic [3:0] eg;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    done_tx   = 1'b0;
    req0      = '0;
    req_data0 = '0;
    done_tx0  = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_din", 64'(din_tx), 64'(0));
    check("rst_du", 64'(data_update), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_te", 64'(timeout_err), 64'(0));
    rst_n = 1'b1;
    tick();

    // single request, payload changes after grant must not disturb din_tx
    req      = 4'b0001;
    req_data = 32'h0000_00A5;
    wait_grant(4'b0001, 8'hA5, "single");
    check("single_busy", 64'(busy), 64'(1));
    check("single_du", 64'(data_update), 64'(1));
    req      = 4'b0000;
    req_data = 32'hFFFF_FFFF;
    tick();
    check("single_gnt_pulse", 64'(gnt), 64'(0));
    check("single_din_hold", 64'(din_tx), 64'(8'hA5));
    finish_frame(4'b0001, 2, "single");
    check("single_din_after", 64'(din_tx), 64'(8'hA5));

    // done_tx already high on SEND entry; a short-lived request meanwhile
    done_tx  = 1'b1;
    req      = 4'b0100;
    req_data = 32'h003C_0000;
    wait_grant(4'b0100, 8'h3C, "hi_entry");
    req = 4'b0010;
    cnt = 0;
    repeat (2) begin tick(); if (done != 4'b0000) cnt++; end
    req = 4'b0000;
    repeat (2) begin tick(); if (done != 4'b0000) cnt++; end
    check("hi_entry_no_done", 64'(cnt), 64'(0));
    check("hi_entry_du", 64'(data_update), 64'(1));
    done_tx = 1'b0;
    tick();
    finish_frame(4'b0100, 1, "hi_entry");
    cnt = 0;
    repeat (5) begin tick(); if (gnt != 4'b0000) cnt++; end
    check("dropped_req_no_gnt", 64'(cnt), 64'(0));
    check("dropped_req_idle", 64'(busy), 64'(0));

    // contention from reset: 0,1,2,3,0
    apply_reset();
    req      = 4'b1111;
    req_data = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      wait_grant(eg, 8'(8'h11 * ((k % 4) + 1)), "cont");
      finish_frame(eg, 2, "cont");
    end

    // wrap: make 3 the last winner, then 1001 -> 0 then 3
    req = 4'b1000;
    wait_grant(4'b1000, 8'h44, "wrap_pre");
    finish_frame(4'b1000, 1, "wrap_pre");
    req = 4'b1001;
    wait_grant(4'b0001, 8'h11, "wrap_a");
    finish_frame(4'b0001, 1, "wrap_a");
    wait_grant(4'b1000, 8'h44, "wrap_b");
    req = 4'b0000;
    finish_frame(4'b1000, 1, "wrap_b");

    // timeout: no done_tx edge, pulse 2000 clocks after entering SEND
    req = 4'b0010;
    wait_grant(4'b0010, 8'h22, "to");
    req = 4'b0000;
    n   = 0;
    cnt = 0;
    while (!timeout_err && n < 2100) begin
      tick();
      n++;
      if (done != 4'b0000) cnt++;
    end
    check("to_latency", 64'(n), 64'(2000));
    check("to_pulse", 64'(timeout_err), 64'(1));
    check("to_du_low", 64'(data_update), 64'(0));
    check("to_no_done", 64'(cnt), 64'(0));
    tick();
    check("to_pulse_one", 64'(timeout_err), 64'(0));
    repeat (3) tick();
    req = 4'b0001;
    wait_grant(4'b0001, 8'h11, "after_to");
    req = 4'b0000;
    finish_frame(4'b0001, 2, "after_to");

    // done_tx edge on the very clock the timeout count is reached
    req = 4'b0100;
    wait_grant(4'b0100, 8'h33, "coinc");
    req = 4'b0000;
    repeat (1999) tick();
    done_tx = 1'b1;
    tick();
    check("coinc_done", 64'(done), 64'(4'b0100));
    check("coinc_no_te", 64'(timeout_err), 64'(0));
    check("coinc_du", 64'(data_update), 64'(0));
    done_tx = 1'b0;
    repeat (4) tick();
    check("coinc_idle", 64'(busy), 64'(0));

    // reset mid-frame: last winner is 2, so 3 would win without the reset
    req = 4'b0100;
    wait_grant(4'b0100, 8'h33, "mid_rst_pre");
    req = 4'b1111;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_din", 64'(din_tx), 64'(0));
    check("mid_rst_du", 64'(data_update), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_te", 64'(timeout_err), 64'(0));
    cnt = 0;
    repeat (5) begin
      tick();
      if (done != 4'b0000 || timeout_err || busy) cnt++;
    end
    check("mid_rst_quiet", 64'(cnt), 64'(0));
    rst_n = 1'b1;
    wait_grant(4'b0001, 8'h11, "post_rst");
    req = 4'b0000;
    finish_frame(4'b0001, 2, "post_rst");

    // dut0: timeout disabled, GAP_CYC=0
    apply_reset();
    req0      = 4'b0001;
    req_data0 = 32'h0000_005A;
    n = 0;
    while (gnt0 == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    check("nto_gnt", 64'(gnt0), 64'(4'b0001));
    check("nto_din", 64'(din_tx0), 64'(8'h5A));
    req0 = 4'b0000;
    cnt  = 0;
    repeat (2100) begin
      tick();
      if (timeout_err0) cnt++;
    end
    check("nto_never", 64'(cnt), 64'(0));
    check("nto_still_send", 64'(data_update0), 64'(1));
    done_tx0 = 1'b1;
    tick();
    check("nto_done", 64'(done0), 64'(4'b0001));
    check("nto_du_low", 64'(data_update0), 64'(0));
    check("nto_gap_busy", 64'(busy0), 64'(1));
    done_tx0 = 1'b0;
    tick();
    check("nto_gap0_idle", 64'(busy0), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
